// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each requester has a one-entry response buffer that can refill while it drains.
module alu_arbiter #(
    parameter int DW   = 32,
    parameter int SELW = 6
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    input  logic [SELW-1:0] req0_sel,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    input  logic [SELW-1:0] req1_sel,

    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [SELW-1:0] alu_select,
    input  logic [DW-1:0]   alu_result,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [DW-1:0]   rsp0_result,
    output logic            rsp0_err,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [DW-1:0]   rsp1_result,
    output logic            rsp1_err,

    output logic [15:0]     grant_cnt0,
    output logic [15:0]     grant_cnt1
);

    localparam logic [SELW-1:0] SEL_MIN = SELW'(19);
    localparam logic [SELW-1:0] SEL_MAX = SELW'(37);

    logic          ptr;
    logic          elig0, elig1;
    logic          gnt0, gnt1;
    logic          legal;
    logic [DW-1:0] cap_result;

    always_comb begin
        elig0      = 1'b0;
        elig1      = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_select = '0;

        // A full buffer that drains this cycle can accept a new result at the same edge.
        if (!reset) begin
            elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
            elig1 = req1_valid & (~rsp1_valid | rsp1_ready);
        end

        gnt0 = elig0 & (~elig1 | ~ptr);
        gnt1 = elig1 & (~elig0 | ptr);

        if (gnt0) begin
            alu_a      = req0_a;
            alu_b      = req0_b;
            alu_select = req0_sel;
        end else if (gnt1) begin
            alu_a      = req1_a;
            alu_b      = req1_b;
            alu_select = req1_sel;
        end

        legal      = (alu_select >= SEL_MIN) && (alu_select <= SEL_MAX);
        cap_result = legal ? alu_result : '0;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= 1'b0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_err    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_err    <= 1'b0;
            grant_cnt0  <= '0;
            grant_cnt1  <= '0;
        end else begin
            // Pointer moves to the loser only when there was real contention.
            if (elig0 && elig1) begin
                ptr <= gnt0;
            end

            if (gnt0) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= cap_result;
                rsp0_err    <= ~legal;
                grant_cnt0  <= grant_cnt0 + 16'd1;
            end else if (rsp0_ready) begin
                rsp0_valid  <= 1'b0;
            end

            if (gnt1) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= cap_result;
                rsp1_err    <= ~legal;
                grant_cnt1  <= grant_cnt1 + 16'd1;
            end else if (rsp1_ready) begin
                rsp1_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus process predicts grants and results,
// a negedge monitor compares buffered responses against the expected queues.
module tb_alu_arbiter;

    localparam int DW   = 32;
    localparam int SELW = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic [SELW-1:0] req0_sel, req1_sel;
    logic [DW-1:0]   alu_a, alu_b, alu_result;
    logic [SELW-1:0] alu_select;
    logic            rsp0_valid, rsp0_ready, rsp0_err;
    logic            rsp1_valid, rsp1_ready, rsp1_err;
    logic [DW-1:0]   rsp0_result, rsp1_result;
    logic [15:0]     grant_cnt0, grant_cnt1;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [DW:0] q0[$];
    logic [DW:0] q1[$];
    bit          occ0, occ1, ptr;
    logic [15:0] cnt0, cnt1;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [SELW-1:0] sel);
        case (sel)
            6'd19:   return a + b;
            6'd20:   return a - b;
            6'd21:   return a & b;
            6'd22:   return a | b;
            6'd37:   return $signed(a) >>> b[4:0];
            default: return a ^ (b + {26'b0, sel});
        endcase
    endfunction

    function automatic logic [DW:0] exp_of(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [SELW-1:0] sel);
        if (sel >= 6'd19 && sel <= 6'd37) return {1'b0, ref_alu(a, b, sel)};
        return {1'b1, {DW{1'b0}}};
    endfunction

    assign alu_result = ref_alu(alu_a, alu_b, alu_select);

    alu_arbiter #(.DW(DW), .SELW(SELW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_err(rsp1_err),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit v0, input bit v1,
                        input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [SELW-1:0] s0,
                        input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [SELW-1:0] s1,
                        input bit r0, input bit r1);
        bit e0, e1, g0, g1;
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
        rsp0_ready = r0; rsp1_ready = r1;
        #1;
        chk("rsp0_valid", rsp0_valid, occ0);
        chk("rsp1_valid", rsp1_valid, occ1);
        chk("grant_cnt0", grant_cnt0, cnt0);
        chk("grant_cnt1", grant_cnt1, cnt1);
        e0 = v0 && (!occ0 || r0);
        e1 = v1 && (!occ1 || r1);
        g0 = e0 && (!e1 || !ptr);
        g1 = e1 && (!e0 || ptr);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("alu_a", alu_a, g0 ? a0 : (g1 ? a1 : '0));
        chk("alu_b", alu_b, g0 ? b0 : (g1 ? b1 : '0));
        chk("alu_select", alu_select, g0 ? s0 : (g1 ? s1 : '0));
        if (g0) begin q0.push_back(exp_of(a0, b0, s0)); cnt0++; end
        if (g1) begin q1.push_back(exp_of(a1, b1, s1)); cnt1++; end
        if (e0 && e1) ptr = g0;
        occ0 = g0 ? 1'b1 : (r0 ? 1'b0 : occ0);
        occ1 = g1 ? 1'b1 : (r1 ? 1'b0 : occ1);
    endtask

    task automatic rand_step(input bit v0, input bit v1, input bit r0, input bit r1);
        step(v0, v1, $urandom(), $urandom(), 6'($urandom_range(0, 63)),
             $urandom(), $urandom(), 6'($urandom_range(0, 63)), r0, r1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk("ready0_in_reset", req0_ready, 1'b0);
        chk("ready1_in_reset", req1_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        occ0 = 0; occ1 = 0; ptr = 0; cnt0 = '0; cnt1 = '0;
        q0.delete(); q1.delete();
        #1;
        chk("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk("rst_grant_cnt0", grant_cnt0, 16'h0);
        chk("rst_grant_cnt1", grant_cnt1, 16'h0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (rsp0_valid) begin
                if (q0.size() == 0) chk("rsp0_unexpected", rsp0_valid, 1'b0);
                else begin
                    chk("rsp0_data", {rsp0_err, rsp0_result}, q0[0]);
                    if (rsp0_ready) void'(q0.pop_front());
                end
            end
            if (rsp1_valid) begin
                if (q1.size() == 0) chk("rsp1_unexpected", rsp1_valid, 1'b0);
                else begin
                    chk("rsp1_data", {rsp1_err, rsp1_result}, q1[0]);
                    if (rsp1_ready) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_sel = '0;
        rsp0_ready = 0; rsp1_ready = 0;
        occ0 = 0; occ1 = 0; ptr = 0; cnt0 = '0; cnt1 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("init_rsp0_valid", rsp0_valid, 1'b0);
        chk("init_rsp1_valid", rsp1_valid, 1'b0);
        chk("init_rsp0_result", rsp0_result, 32'h0);
        chk("init_rsp1_err", rsp1_err, 1'b0);
        chk("init_grant_cnt0", grant_cnt0, 16'h0);

        // single add request, one-cycle latency
        step(1, 0, 32'hA, 32'h5, 6'b010011, '0, '0, '0, 1, 1);
        step(0, 0, '0, '0, '0, '0, '0, '0, 1, 1);
        chk("single_result", rsp0_result, 32'hF);
        chk("single_err", rsp0_err, 1'b0);
        chk("single_cnt0", grant_cnt0, 16'd1);

        // contention with free-flowing responses
        repeat (8) step(1, 1, $urandom(), $urandom(), 6'd19, $urandom(), $urandom(), 6'd20, 1, 1);

        // backpressure on buffer 0
        rand_step(1, 0, 1, 1);
        repeat (6) rand_step(1, 1, 0, 1);
        rand_step(0, 0, 1, 1);

        // illegal code then arithmetic shift right
        step(0, 1, '0, '0, '0, 32'h1, 32'h2, 6'b111111, 1, 1);
        step(0, 1, '0, '0, '0, 32'hFFFF_FFE0, 32'd4, 6'b100101, 1, 1);
        chk("illegal_result", rsp1_result, 32'h0);
        chk("illegal_err", rsp1_err, 1'b1);
        step(0, 0, '0, '0, '0, '0, '0, '0, 1, 1);
        chk("sra_result", rsp1_result, 32'hFFFF_FFFE);
        chk("sra_err", rsp1_err, 1'b0);

        // reset with data buffered and requester 1 pending
        rand_step(1, 0, 0, 0);
        rand_step(0, 1, 0, 0);
        rand_step(0, 1, 0, 0);
        do_reset();
        rand_step(1, 1, 1, 1);

        // randomized traffic
        repeat (400) rand_step($urandom_range(0, 1), $urandom_range(0, 1),
                               $urandom_range(0, 1), $urandom_range(0, 1));

        // grant counter wrap
        do_reset();
        repeat (65536) rand_step(1, 0, 1, 1);
        step(0, 0, '0, '0, '0, '0, '0, '0, 1, 1);
        chk("wrap_cnt0", grant_cnt0, 16'h0000);

        repeat (2) step(0, 0, '0, '0, '0, '0, '0, '0, 1, 1);
        @(posedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DW, default 32, SHALL set the operand and result width.
REQ-002 Parameter SELW, default 6, SHALL set the aluSelect code width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) SHALL indicate that requester N presents an operation.
REQ-006 reqN_ready  output  1  SHALL indicate that requester N's operation is accepted this cycle.
REQ-007 reqN_a, reqN_b  input  DW  SHALL be requester N's operands.
REQ-008 reqN_sel  input  SELW  SHALL be requester N's aluSelect code.
REQ-009 alu_a, alu_b  output  DW  SHALL drive the shared combinational ALU's operands.
REQ-010 alu_select  output  SELW  SHALL drive the shared ALU's aluSelect.
REQ-011 alu_result  input  DW  SHALL be the shared ALU's combinational result.
REQ-012 rspN_valid  output  1  SHALL indicate that response buffer N holds a result.
REQ-013 rspN_ready  input  1  SHALL indicate that consumer N takes the response this cycle.
REQ-014 rspN_result  output  DW  SHALL be the buffered result for requester N.
REQ-015 rspN_err  output  1  SHALL flag an illegal select code for the buffered result.
REQ-016 grant_cnt0, grant_cnt1  output  16  SHALL count grants per requester.

Function
REQ-017 Requester N SHALL be eligible when reqN_valid=1 and response buffer N is empty or draining this cycle (rspN_valid & rspN_ready).
REQ-018 At most one grant per cycle; if one requester is eligible, it SHALL be granted.
REQ-019 If both are eligible, the requester selected by the 1-bit round-robin pointer SHALL be granted; the pointer SHALL then point to the other requester.
REQ-020 The pointer SHALL change only on a grant made while both requesters are eligible.
REQ-021 reqN_ready SHALL be high combinationally only in the cycle requester N is granted; the handshake is reqN_valid & reqN_ready.
REQ-022 alu_a/alu_b/alu_select SHALL carry the granted requester's inputs; with no grant they SHALL be 0.
REQ-023 On a grant, alu_result SHALL be captured into buffer N at the same edge: latency is 1 cycle from accept to rspN_valid=1.
REQ-024 A code is legal iff 19 <= sel <= 37 (6'b010011..6'b100101); for an illegal code the buffer SHALL store result 0 with rspN_err=1, otherwise err=0.
REQ-025 rspN_valid, rspN_result and rspN_err SHALL hold stable until rspN_ready=1.
REQ-026 Drain and refill of buffer N in the same cycle SHALL leave rspN_valid=1 with the new result (back-to-back throughput of 1 per cycle).
REQ-027 Drain without refill SHALL clear rspN_valid at the edge.
REQ-028 grant_cntN SHALL increment by 1 per grant to N and wrap 0xFFFF -> 0x0000.
REQ-029 A requester whose buffer is full and not draining SHALL NOT block the other requester.

Reset
REQ-030 While reset=1 at an edge: rsp0/1_valid=0, rsp0/1_result=0, rsp0/1_err=0, pointer=0 (requester 0 first), grant_cnt0/1=0.
REQ-031 While reset=1, reqN_ready SHALL be 0 and no operation SHALL be accepted; in-flight buffered results SHALL be discarded.

Verification
REQ-032 Single: req0 a=0xA, b=0x5, sel=010011 -> ready0 for 1 cycle; next cycle rsp0_valid=1, rsp0_result=0xF, err=0; grant_cnt0=1.
REQ-033 Contention: both valid continuously, rsp ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; one result per cycle.
REQ-034 Backpressure: rsp0_ready=0 with buffer 0 full, req0 and req1 valid -> req0 stalled, req1 granted each cycle; rsp0 data held unchanged.
REQ-035 Illegal code: req1 sel=111111 -> rsp1_result=0, rsp1_err=1; sel=100101 (SRA, a=-32, b=4) -> 0xFFFFFFFE, err=0.
REQ-036 Reset mid-operation: assert reset with rsp0_valid=1 and req1 pending -> next cycle all rsp*_valid=0, counters 0, pointer favours requester 0.
REQ-037 Counter wrap: force 65536 grants to requester 0 -> grant_cnt0 returns to 0x0000.
